// File: rtl/alu_pipe_if.sv
// Request/result bundle between decode, the ALU and writeback.
// No latency of its own; it only groups wires.
// Request uses in_valid/in_ready and result uses out_valid/out_ready; each side stalls the other through these pairs.
interface alu_pipe_if #(
    parameter int W   = 8,
    parameter int OPW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] opcode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           c_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   y;
    logic           c_out;
    logic           v;
    logic           n;
    logic           z;
    logic           err;

    // Producer of requests and consumer of results (decode / writeback side).
    modport master (
        output in_valid, opcode, a, b, c_in, out_ready,
        input  in_ready, out_valid, y, c_out, v, n, z, err
    );

    // The ALU itself.
    modport slave (
        input  in_valid, opcode, a, b, c_in, out_ready,
        output in_ready, out_valid, y, c_out, v, n, z, err
    );
endinterface

// File: rtl/alu_pipe.sv
// Sequential ALU with registered C/V/N/Z/err flags and an iterative shift-add multiplier.
// Latency: 1 cycle for every opcode except MUL; MUL takes W cycles, and in_ready stays low while it runs.
// Backpressure: the result register holds while out_valid && !out_ready; a new request is taken only when that register is free or draining this cycle.
module alu_pipe #(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int CW = $clog2(W) + 1;

    localparam logic [OPW-1:0] OP_LSL = OPW'(0);
    localparam logic [OPW-1:0] OP_LSR = OPW'(1);
    localparam logic [OPW-1:0] OP_ASL = OPW'(2);
    localparam logic [OPW-1:0] OP_ASR = OPW'(3);
    localparam logic [OPW-1:0] OP_NOT = OPW'(4);
    localparam logic [OPW-1:0] OP_AND = OPW'(5);
    localparam logic [OPW-1:0] OP_OR  = OPW'(6);
    localparam logic [OPW-1:0] OP_XOR = OPW'(7);
    localparam logic [OPW-1:0] OP_ADD = OPW'(8);
    localparam logic [OPW-1:0] OP_SUB = OPW'(9);
    localparam logic [OPW-1:0] OP_MUL = OPW'(10);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    y_q, y_d;
    logic            c_q, c_d;
    logic            v_q, v_d;
    logic            z_q, z_d;
    logic            err_q, err_d;

    logic            accept;
    logic            mul_last;
    logic [2*W-1:0]  mul_sum;

    logic [W:0]          lsl_t;
    logic [W:0]          a_ext;
    logic [W:0]          lsr_t;
    logic signed [W:0]   asr_t;
    logic [W:0]          add_t;
    logic [W:0]          sub_t;
    logic                asl_v;

    logic [W-1:0]    alu_y;
    logic            alu_c;
    logic            alu_v;
    logic            alu_err;

    // Ready only when idle and the result slot is empty or being drained; forced low in reset.
    assign bus.in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Shifts carry an extra guard bit so the last bit shifted out lands in a fixed position.
    // Shift amounts beyond W fall out of these expressions without special cases.
    assign lsl_t = {1'b0, bus.a} << bus.b;
    assign a_ext = {bus.a, 1'b0};
    assign lsr_t = a_ext >> bus.b;
    assign asr_t = $signed(a_ext) >>> bus.b;
    assign add_t = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.c_in};
    assign sub_t = {1'b0, bus.a} + {1'b0, ~bus.b} + {{W{1'b0}}, bus.c_in};

    // ASL overflow: after i shifts the sign bit is a[W-1-i] (zero once a is exhausted); flag if any differs from a's sign.
    always_comb begin
        asl_v = 1'b0;
        for (int i = 1; i <= W; i++) begin
            if ((bus.b >= W'(i)) && (a_ext[W-i] != bus.a[W-1])) begin
                asl_v = 1'b1;
            end
        end
    end

    // Single-cycle result for every opcode except MUL.
    always_comb begin
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (bus.opcode)
            OP_LSL: begin alu_y = lsl_t[W-1:0]; alu_c = lsl_t[W]; end
            OP_ASL: begin alu_y = lsl_t[W-1:0]; alu_c = lsl_t[W]; alu_v = asl_v; end
            OP_LSR: begin alu_y = lsr_t[W:1];   alu_c = lsr_t[0]; end
            OP_ASR: begin alu_y = asr_t[W:1];   alu_c = asr_t[0]; end
            OP_NOT: alu_y = ~bus.a;
            OP_AND: alu_y = bus.a & bus.b;
            OP_OR:  alu_y = bus.a | bus.b;
            OP_XOR: alu_y = bus.a ^ bus.b;
            OP_ADD: begin
                alu_y = add_t[W-1:0];
                alu_c = add_t[W];
                alu_v = (bus.a[W-1] == bus.b[W-1]) && (add_t[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                alu_y = sub_t[W-1:0];
                alu_c = sub_t[W];
                alu_v = (bus.a[W-1] != bus.b[W-1]) && (sub_t[W-1] != bus.a[W-1]);
            end
            default: alu_err = 1'b1;
        endcase
    end

    // The accept edge performs the first multiplier step; each busy cycle performs one more.
    assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});
    assign mul_last = (cnt_q == CW'(W - 1));

    // Next-state and output-register logic for the IDLE / MUL_BUSY controller.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        y_d         = y_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.opcode == OP_MUL) begin
                        state_d  = ST_MUL;
                        acc_d    = {{W{1'b0}}, bus.a & {W{bus.b[0]}}};
                        mcand_d  = {{(W-1){1'b0}}, bus.a, 1'b0};
                        mplier_d = bus.b >> 1;
                        cnt_d    = CW'(1);
                    end else begin
                        out_valid_d = 1'b1;
                        y_d         = alu_y;
                        c_d         = alu_c;
                        v_d         = alu_v;
                        z_d         = (alu_y == '0);
                        err_d       = alu_err;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (mul_last) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    y_d         = mul_sum[W-1:0];
                    c_d         = |mul_sum[2*W-1:W];
                    v_d         = |mul_sum[2*W-1:W];
                    z_d         = (mul_sum[W-1:0] == '0);
                    err_d       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, multiplier and result registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            c_q         <= c_d;
            v_q         <= v_d;
            z_q         <= z_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.c_out     = c_q;
    assign bus.v         = v_q;
    assign bus.n         = y_q[W-1];
    assign bus.z         = z_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at W=8: directed corner cases, then randomized traffic against a reference model.
// Reference latency: 1 cycle for most ops and 8 cycles for MUL.
// Backpressure is exercised by random out_ready values and by a directed 3-cycle stall.
module tb_alu_pipe;
    localparam int W = 8;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       v;
        logic       err;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_pipe_if #(.W(W), .OPW(4)) bus ();

    alu_pipe #(.W(W), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: shifts are performed one bit at a time; arithmetic uses plain integer values.
    function automatic res_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
        res_t r;
        int val, steps, sum, sa, sb, s, nb, p;
        r.y = 8'h00; r.c = 1'b0; r.v = 1'b0; r.err = 1'b0;
        steps = (int'(b) > 9) ? 9 : int'(b);
        val = int'(a);
        sa = a[7] ? int'(a) - 256 : int'(a);
        case (op)
            4'd0, 4'd2: begin
                for (int i = 0; i < steps; i++) begin
                    r.c = val[7];
                    val = (val << 1) & 255;
                    if (op == 4'd2 && val[7] != a[7]) r.v = 1'b1;
                end
                r.y = val[7:0];
            end
            4'd1: begin
                for (int i = 0; i < steps; i++) begin
                    r.c = val[0];
                    val = val >> 1;
                end
                r.y = val[7:0];
            end
            4'd3: begin
                for (int i = 0; i < steps; i++) begin
                    r.c = val[0];
                    val = (val >> 1) | (val & 128);
                end
                r.y = val[7:0];
            end
            4'd4: r.y = ~a;
            4'd5: r.y = a & b;
            4'd6: r.y = a | b;
            4'd7: r.y = a ^ b;
            4'd8: begin
                sum = int'(a) + int'(b) + int'(ci);
                r.y = sum[7:0];
                r.c = sum[8];
                sb  = b[7] ? int'(b) - 256 : int'(b);
                s   = sa + sb + int'(ci);
                r.v = (s > 127) || (s < -128);
            end
            4'd9: begin
                nb  = 255 - int'(b);
                sum = int'(a) + nb + int'(ci);
                r.y = sum[7:0];
                r.c = sum[8];
                sb  = (nb > 127) ? nb - 256 : nb;
                s   = sa + sb + int'(ci);
                r.v = (s > 127) || (s < -128);
            end
            4'd10: begin
                p   = int'(a) * int'(b);
                r.y = p[7:0];
                r.c = (p > 255);
                r.v = (p > 255);
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check_out(input string tag, input res_t e);
        chk({tag, "_y"},   32'(bus.y),     32'(e.y));
        chk({tag, "_c"},   32'(bus.c_out), 32'(e.c));
        chk({tag, "_v"},   32'(bus.v),     32'(e.v));
        chk({tag, "_n"},   32'(bus.n),     32'(e.y[7]));
        chk({tag, "_z"},   32'(bus.z),     32'(e.y == 8'h00));
        chk({tag, "_err"}, 32'(bus.err),   32'(e.err));
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = ci;
    endtask

    // Issue one op with out_ready=1, scramble inputs after accept, return at the negedge where out_valid is seen.
    task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input int exp_lat);
        int guard;
        int lat;
        @(posedge clk); #1;
        drive(op, a, b, ci);
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'($urandom);
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.c_in     = 1'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            if (op == 4'd10) chk({tag, "_busy_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_out(tag, model(op, a, b, ci));
    endtask

    res_t       exp_q[$];
    res_t       e;
    logic       hold_pend;
    logic [7:0] hold_y;
    logic       seen_vld;
    int         guard;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_y",         32'(bus.y),         32'd0);
        chk("rst_flags",     {28'd0, bus.c_out, bus.v, bus.n, bus.z}, 32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed arithmetic / shift corner cases.
        issue("add_ovf", 4'd8, 8'h7F, 8'h01, 1'b0, 1);
        chk("add_ovf_y_const", 32'(bus.y), 32'h80);
        chk("add_ovf_v_const", 32'(bus.v), 32'd1);
        issue("sub_bor", 4'd9, 8'h00, 8'h01, 1'b1, 1);
        chk("sub_bor_y_const", 32'(bus.y), 32'hFF);
        chk("sub_bor_c_const", 32'(bus.c_out), 32'd0);
        issue("add_wrap", 4'd8, 8'hFF, 8'h01, 1'b0, 1);
        chk("add_wrap_cz_const", {30'd0, bus.c_out, bus.z}, 32'd3);
        issue("asr2", 4'd3, 8'h90, 8'd2, 1'b0, 1);
        chk("asr2_y_const", 32'(bus.y), 32'hE4);
        issue("asr9", 4'd3, 8'h90, 8'd9, 1'b0, 1);
        chk("asr9_yc_const", {23'd0, bus.y, bus.c_out}, {23'd0, 8'hFF, 1'b1});
        issue("lsr1", 4'd1, 8'h81, 8'd1, 1'b0, 1);
        chk("lsr1_yc_const", {23'd0, bus.y, bus.c_out}, {23'd0, 8'h40, 1'b1});
        issue("lsl8", 4'd0, 8'h81, 8'd8, 1'b0, 1);
        issue("lsl200", 4'd0, 8'hFF, 8'd200, 1'b0, 1);
        issue("asl_ovf", 4'd2, 8'h40, 8'd1, 1'b0, 1);
        issue("asl_ok", 4'd2, 8'hE0, 8'd2, 1'b0, 1);
        issue("mul", 4'd10, 8'h10, 8'h10, 1'b1, 8);
        chk("mul_cvz_const", {29'd0, bus.c_out, bus.v, bus.z}, 32'd7);
        issue("mul2", 4'd10, 8'hFF, 8'hFF, 1'b0, 8);
        issue("illegal", 4'd12, 8'h55, 8'h22, 1'b0, 1);
        chk("illegal_err_const", 32'(bus.err), 32'd1);
        issue("legal_after", 4'd8, 8'h01, 8'h02, 1'b0, 1);

        // Back-to-back ADD/XOR/NOT: one result per cycle, in order.
        @(posedge clk); #1;
        drive(4'd8, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        chk("b2b_rdy0", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        drive(4'd7, 8'hF0, 8'h3C, 1'b0);
        @(negedge clk);
        chk("b2b_v0", 32'(bus.out_valid), 32'd1);
        chk("b2b_y0", 32'(bus.y), 32'h46);
        chk("b2b_rdy1", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        drive(4'd4, 8'h5A, 8'h00, 1'b0);
        @(negedge clk);
        chk("b2b_y1", 32'(bus.y), 32'hCC);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_y2", 32'(bus.y), 32'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_drained", 32'(bus.out_valid), 32'd0);

        // Output stall for 3 cycles, then drain and accept in the same cycle.
        @(posedge clk); #1;
        drive(4'd8, 8'h01, 8'h01, 1'b0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(4'd6, 8'h0F, 8'hF0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_vld", 32'(bus.out_valid), 32'd1);
            chk("stall_y",   32'(bus.y),         32'h02);
            chk("stall_rdy", 32'(bus.in_ready),  32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("release_vld", 32'(bus.out_valid), 32'd1);
        chk("release_y",   32'(bus.y),         32'hFF);

        // Reset in the middle of a MUL: no result appears.
        @(posedge clk); #1;
        drive(4'd10, 8'h03, 8'h05, 1'b0);
        @(negedge clk);
        chk("mulrst_acc", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mulrst_rdy_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_vld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_vld = seen_vld | bus.out_valid;
        end
        chk("mulrst_no_out", 32'(seen_vld), 32'd0);
        chk("mulrst_rdy", 32'(bus.in_ready), 32'd1);

        // Randomized traffic with random backpressure against the reference model.
        hold_pend = 1'b0;
        hold_y    = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.opcode    = 4'($urandom_range(0, 15));
            bus.a         = 8'($urandom);
            bus.b         = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            bus.c_in      = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (hold_pend) begin
                chk("rnd_hold_vld", 32'(bus.out_valid), 32'd1);
                chk("rnd_hold_y",   32'(bus.y),         32'(hold_y));
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_y    = bus.y;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_out("rnd", e);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.opcode, bus.a, bus.b, bus.c_in));
            end
        end

        // Drain outstanding results.
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                check_out("drain", e);
            end
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
